kicker_ctrl: RTL and testbench
==============================

// Module: kicker_ctrl
// PURPOSE
//  Multi-channel solenoid kicker controller: charges HV cap via charger IC, fires one of N_CH
//  trigger outputs (flat kick, chip, ...) for a programmed pulse width, then enforces cooldown.
//  Sits between command decoder (kicktime/kickstart/kick_ch) and charger/IGBT pins on board.
// PARAMETERS
//  N_CH        2     number of trigger channels (1..8)
//  TIME_W      8     width of kicktime
//  TICK_DIV    1000  clk cycles per kicktime unit (>=2)
//  COOL_TICKS  200   cooldown after fire, in ticks
//  CHG_TO      5000  charge timeout, in ticks (16-bit counter)
// PORTS
//  clk        in   1            system clock
//  rst        in   1            synchronous, active-high reset
//  kicktime   in   TIME_W       pulse width in ticks; 0 = no fire
//  kickstart  in   1            kick request, level; rising edge acts
//  kick_ch    in   clog2(N_CH)  channel select, sampled on kickstart edge (width 1 if N_CH=1)
//  done       in   1            charger "cap full", async, active-high
//  fault_clr  in   1            clears FAULT, single-cycle pulse
//  Charge     out  1            charger enable
//  Trigger    out  N_CH         one-hot fire outputs, registered
//  ready      out  1            cap charged, request accepted next edge
//  led3       out  1            = ready
//  led4       out  1            = FAULT state
// BEHAVIOUR
//  - done through 2-flop synchroniser (2-cycle latency); kickstart edge-detected, held level fires once.
//  - Reset: all outputs 0, FSM->CHARGE, counters 0; Charge goes 1 first cycle after rst low.
//  - Prescaler: tick every TICK_DIV clk; cleared on every state entry, so durations are exact.
//  - FSM states:
//    CHARGE: Charge=1. done_sync=1 -> READY. CHG_TO ticks without done -> FAULT.
//    READY: Charge=0, ready=1. Valid edge (kicktime!=0, kick_ch<N_CH) -> FIRE, latch
//      kicktime/kick_ch. Invalid edge ignored, stays READY. done drop -> CHARGE.
//    FIRE: Trigger[ch]=1 exactly kicktime*TICK_DIV clk, from cycle after edge sample; Charge=0.
//      kickstart/kicktime changes ignored. End -> COOLDOWN.
//    COOLDOWN: all outputs 0 for COOL_TICKS*TICK_DIV clk -> CHARGE.
//    FAULT: Charge=0, Trigger=0, led4=1; fault_clr -> CHARGE; requests ignored.
//  - Requests outside READY are dropped, not queued; an edge seen in CHARGE never fires later.
//  - Trigger and Charge never both 1; at most one Trigger bit set (checked by assertion).
//  - rst mid-FIRE: Trigger drops the cycle rst is sampled.
//  - Simultaneous fault_clr and CHG_TO expiry in same cycle: FAULT entry wins.
// CONFIGURATION
//  KICKER_BALLSENSE_EN defined: adds input ball_in (async, 2-flop synced) and parameter
//   ARM_TICKS (default 500). Valid edge in READY enters ARMED (ready=0, Charge=0);
//   fires when ball_in_sync=1; leaves to READY if kickstart drops or ARM_TICKS expire.
//  Undefined: no ball_in port, no ARMED state; valid edge fires immediately.
// TESTING (sim: TICK_DIV=4, COOL_TICKS=3, CHG_TO=20, N_CH=2)
//  1 rst, done=1 at cycle 10 -> Charge=1 from cycle 1, ready=1 two cycles after done, Charge=0.
//  2 READY, kicktime=5, kick_ch=1, kickstart rise -> Trigger=2'b10 for 20 clk, then 12 clk
//    cooldown, then Charge=1.
//  3 kickstart held high 1000 cycles, kicktime=127 -> exactly one 508-clk pulse.
//  4 done held 0 -> FAULT after 80 clk, led4=1; fault_clr -> Charge=1 next cycle.
//  5 kicktime=0 or kick_ch=2 in READY -> no Trigger, stays READY; rst mid-FIRE -> Trigger=0.
//  6 BALLSENSE_EN: arm, ball_in=1 at +30 clk -> fire 2 clk after; no ball -> READY after 2000 clk.

Source files
------------

// File: rtl/kicker_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : kicker_ctrl
// Description : Multi-channel solenoid kicker controller. It charges the HV
//               capacitor, fires one one-hot trigger for a timed pulse, then
//               waits out a cooldown. Optional ball-sense arming is enabled
//               with the KICKER_BALLSENSE_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module kicker_ctrl #(
    parameter int N_CH       = 2,
    parameter int TIME_W     = 8,
    parameter int TICK_DIV   = 1000,
    parameter int COOL_TICKS = 200,
    parameter int CHG_TO     = 5000,
`ifdef KICKER_BALLSENSE_EN
    parameter int ARM_TICKS  = 500,
`endif
    localparam int c_CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TIME_W-1:0] kicktime,
    input  logic              kickstart,
    input  logic [c_CH_W-1:0] kick_ch,
    input  logic              done,
    input  logic              fault_clr,
`ifdef KICKER_BALLSENSE_EN
    input  logic              ball_in,
`endif
    output logic              Charge,
    output logic [N_CH-1:0]   Trigger,
    output logic              ready,
    output logic              led3,
    output logic              led4
);

    localparam int         c_PRE_W    = $clog2(TICK_DIV);
    localparam logic [2:0] c_CHARGE   = 3'd0;
    localparam logic [2:0] c_READY    = 3'd1;
    localparam logic [2:0] c_FIRE     = 3'd2;
    localparam logic [2:0] c_COOLDOWN = 3'd3;
    localparam logic [2:0] c_FAULT    = 3'd4;
`ifdef KICKER_BALLSENSE_EN
    localparam logic [2:0] c_ARMED    = 3'd5;
`endif

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic               r_done_s1;
    logic               r_done_s2;
    logic               r_ks_d;
    logic [c_PRE_W-1:0] r_presc;
    logic [15:0]        r_ticks;
    logic [TIME_W-1:0]  r_kt;
    logic [c_CH_W-1:0]  r_ch;
    logic               r_charge;
    logic [N_CH-1:0]    r_trigger;
    logic               r_ready;
    logic               r_fault;

    logic               w_tick;
    logic [15:0]        w_ticks_inc;
    logic               w_rise;
    logic               w_valid;
    logic               w_enter;
    logic [c_CH_W-1:0]  w_fire_ch;
    logic [N_CH-1:0]    w_trig_oh;

`ifdef KICKER_BALLSENSE_EN
    logic               r_ball_s1;
    logic               r_ball_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ball_s1 <= 1'b0;
            r_ball_s2 <= 1'b0;
        end else begin
            r_ball_s1 <= ball_in;
            r_ball_s2 <= r_ball_s1;
        end
    end
`endif

    assign w_tick      = (r_presc == c_PRE_W'(TICK_DIV - 1));
    assign w_ticks_inc = r_ticks + 16'd1;
    assign w_rise      = kickstart & ~r_ks_d;
    assign w_valid     = w_rise && (kicktime != '0) && (32'(kick_ch) < N_CH);
    assign w_enter     = (w_state_nxt != r_state);
    // The live channel select only matters on the cycle the request is taken.
    assign w_fire_ch   = (r_state == c_READY) ? kick_ch : r_ch;

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_trig
            assign w_trig_oh[i] = (w_fire_ch == c_CH_W'(i));
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_CHARGE: begin
                if (r_done_s2)
                    w_state_nxt = c_READY;
                else if (w_tick && (w_ticks_inc == 16'(CHG_TO)))
                    w_state_nxt = c_FAULT;
            end
            c_READY: begin
                if (!r_done_s2)
                    w_state_nxt = c_CHARGE;
                else if (w_valid)
`ifdef KICKER_BALLSENSE_EN
                    w_state_nxt = c_ARMED;
`else
                    w_state_nxt = c_FIRE;
`endif
            end
`ifdef KICKER_BALLSENSE_EN
            c_ARMED: begin
                if (r_ball_s2)
                    w_state_nxt = c_FIRE;
                else if (!kickstart || (w_tick && (w_ticks_inc == 16'(ARM_TICKS))))
                    w_state_nxt = c_READY;
            end
`endif
            c_FIRE: begin
                if (w_tick && (w_ticks_inc == 16'(r_kt)))
                    w_state_nxt = c_COOLDOWN;
            end
            c_COOLDOWN: begin
                if (w_tick && (w_ticks_inc == 16'(COOL_TICKS)))
                    w_state_nxt = c_CHARGE;
            end
            c_FAULT: begin
                if (fault_clr)
                    w_state_nxt = c_CHARGE;
            end
            default: w_state_nxt = c_CHARGE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_CHARGE;
            r_done_s1 <= 1'b0;
            r_done_s2 <= 1'b0;
            r_ks_d    <= 1'b0;
            r_presc   <= '0;
            r_ticks   <= '0;
            r_kt      <= '0;
            r_ch      <= '0;
            r_charge  <= 1'b0;
            r_trigger <= '0;
            r_ready   <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_done_s1 <= done;
            r_done_s2 <= r_done_s1;
            r_ks_d    <= kickstart;

            // Timebase restarts on every state entry so each duration is exact.
            if (w_enter) begin
                r_presc <= '0;
                r_ticks <= '0;
            end else if (w_tick) begin
                r_presc <= '0;
                r_ticks <= w_ticks_inc;
            end else begin
                r_presc <= r_presc + c_PRE_W'(1);
            end

            if ((r_state == c_READY) && w_valid) begin
                r_kt <= kicktime;
                r_ch <= kick_ch;
            end

            // Outputs decode the next state so they line up with the state register.
            r_charge  <= (w_state_nxt == c_CHARGE);
            r_ready   <= (w_state_nxt == c_READY);
            r_fault   <= (w_state_nxt == c_FAULT);
            r_trigger <= (w_state_nxt == c_FIRE) ? w_trig_oh : '0;
        end
    end

    assign Charge  = r_charge;
    assign Trigger = r_trigger;
    assign ready   = r_ready;
    assign led3    = r_ready;
    assign led4    = r_fault;

    a_trig_safe: assert property (@(posedge clk) disable iff (rst)
        !((|r_trigger) && r_charge) && $onehot0(r_trigger));

endmodule
`default_nettype wire

// File: tb/tb_kicker_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_kicker_ctrl
// Description : Scoreboard bench for kicker_ctrl (default build, no ball sense).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kicker_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] kicktime;
    logic       kickstart;
    logic       kick_ch;
    logic       done;
    logic       fault_clr;
    logic       Charge;
    logic [1:0] Trigger;
    logic       ready;
    logic       led3;
    logic       led4;

    logic [1:0] kick_ch3;
    logic       Charge3;
    logic [2:0] Trigger3;
    logic       ready3;
    logic       led3_3;
    logic       led4_3;

    kicker_ctrl #(
        .N_CH(2), .TIME_W(8), .TICK_DIV(4), .COOL_TICKS(3), .CHG_TO(20)
    ) u_dut (
        .clk(clk), .rst(rst), .kicktime(kicktime), .kickstart(kickstart),
        .kick_ch(kick_ch), .done(done), .fault_clr(fault_clr),
        .Charge(Charge), .Trigger(Trigger), .ready(ready), .led3(led3), .led4(led4)
    );

    // Three-channel instance so an out-of-range channel select is representable.
    kicker_ctrl #(
        .N_CH(3), .TIME_W(8), .TICK_DIV(4), .COOL_TICKS(3), .CHG_TO(20)
    ) u_dut3 (
        .clk(clk), .rst(rst), .kicktime(kicktime), .kickstart(kickstart),
        .kick_ch(kick_ch3), .done(done), .fault_clr(fault_clr),
        .Charge(Charge3), .Trigger(Trigger3), .ready(ready3), .led3(led3_3), .led4(led4_3)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [5:0] val;
        string      name;
    } exp_t;

    exp_t       exq[$];
    int         cyc       = 0;
    int         n_checks  = 0;
    int         n_errors  = 0;
    logic       u3_fired  = 1'b0;
    logic [5:0] w_outs;
    logic [5:0] r_prev;

    assign w_outs = {Charge, Trigger, ready, led3, led4};

    function automatic logic [5:0] pk(logic c, logic [1:0] t, logic r, logic f);
        return {c, t, r, r, f};
    endfunction

    task automatic expect_at(int c, logic [5:0] v, string n);
        exq.push_back('{cyc: c, val: v, name: n});
    endtask

    task automatic at(int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic check(string n, logic [7:0] got, logic [7:0] req);
        n_checks++;
        if (got !== req) begin
            n_errors++;
            $display("FAIL %s: got %b, required %b (cycle %0d)", n, got, req, cyc);
        end
    endtask

    // Monitor: every output change is matched against the next expected event.
    initial begin
        exp_t e;
        r_prev = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            if (Trigger3 != 3'b000) u3_fired = 1'b1;
            if (cyc == 1 || w_outs !== r_prev) begin
                n_checks++;
                if (exq.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected: cycle %0d outputs=%b, no change required", cyc, w_outs);
                end else begin
                    e = exq.pop_front();
                    if (e.cyc != cyc || e.val !== w_outs) begin
                        n_errors++;
                        $display("FAIL %s: got cycle %0d outputs=%b, required cycle %0d outputs=%b",
                                 e.name, cyc, w_outs, e.cyc, e.val);
                    end
                end
            end
            r_prev = w_outs;
        end
    end

    // Stimulus: output vector is {Charge, Trigger[1:0], ready, led3, led4}.
    initial begin
        exp_t e;
        rst = 1'b1; kicktime = '0; kickstart = 1'b0; kick_ch = 1'b0;
        done = 1'b0; fault_clr = 1'b0; kick_ch3 = 2'd3;
        expect_at(1, pk(0, 2'b00, 0, 0), "reset");

        at(2);  rst = 1'b0;
        expect_at(3, pk(1, 2'b00, 0, 0), "charge_on");

        at(9);  done = 1'b1;
        expect_at(12, pk(0, 2'b00, 1, 0), "ready");

        at(14); kicktime = 8'd5; kick_ch = 1'b1; kickstart = 1'b1;
        expect_at(15, pk(0, 2'b10, 0, 0), "fire_ch1");
        expect_at(35, pk(0, 2'b00, 0, 0), "cool_ch1");
        expect_at(47, pk(1, 2'b00, 0, 0), "recharge_1");
        expect_at(48, pk(0, 2'b00, 1, 0), "ready_2");
        at(50); kickstart = 1'b0;

        at(52); kicktime = 8'd127; kick_ch = 1'b0; kickstart = 1'b1;
        expect_at(53,  pk(0, 2'b01, 0, 0), "fire_long");
        expect_at(561, pk(0, 2'b00, 0, 0), "cool_long");
        expect_at(573, pk(1, 2'b00, 0, 0), "recharge_2");
        expect_at(574, pk(0, 2'b00, 1, 0), "ready_3");
        at(100); kicktime = 8'd3; kick_ch = 1'b1;

        at(600);
        check("bad_ch_ready", {7'd0, ready3}, 8'd1);
        check("bad_ch_trig", {5'd0, Trigger3}, 8'd0);
        at(1052); kickstart = 1'b0;

        at(1060); kicktime = 8'd0; kickstart = 1'b1;
        at(1062); kickstart = 1'b0;
        at(1066);
        check("kt_zero_ready", {7'd0, ready}, 8'd1);

        at(1070); kicktime = 8'd2; kick_ch = 1'b0; kickstart = 1'b1;
        expect_at(1071, pk(0, 2'b01, 0, 0), "fire_short");
        at(1074); rst = 1'b1; kickstart = 1'b0;
        expect_at(1075, pk(0, 2'b00, 0, 0), "rst_mid_fire");
        at(1076); rst = 1'b0;
        expect_at(1077, pk(1, 2'b00, 0, 0), "charge_after_rst");
        expect_at(1079, pk(0, 2'b00, 1, 0), "ready_after_rst");

        at(1090); done = 1'b0;
        expect_at(1093, pk(1, 2'b00, 0, 0), "done_drop");
        expect_at(1173, pk(0, 2'b00, 0, 1), "charge_timeout");
        at(1172); fault_clr = 1'b1;
        at(1173); fault_clr = 1'b0;
        at(1180); kicktime = 8'd4; kickstart = 1'b1;
        at(1182); kickstart = 1'b0;
        at(1186);
        check("fault_led4", {7'd0, led4}, 8'd1);
        at(1190); fault_clr = 1'b1;
        expect_at(1191, pk(1, 2'b00, 0, 0), "fault_clear");
        at(1191); fault_clr = 1'b0;
        at(1200); done = 1'b1;
        expect_at(1203, pk(0, 2'b00, 1, 0), "ready_final");

        at(1220);
        check("bad_ch_never_fired", {7'd0, u3_fired}, 8'd0);
        check("bad_ch_ready_final", {7'd0, ready3}, 8'd1);
        while (exq.size() != 0) begin
            e = exq.pop_front();
            n_checks++;
            n_errors++;
            $display("FAIL %s: no output change seen, required cycle %0d outputs=%b",
                     e.name, e.cyc, e.val);
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
